// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module      : cache_control
// Description : Sequencing FSM for a 2-way set-associative, write-back,
//               write-allocate L1 cache datapath. Hits are answered in the
//               same cycle from IDLE. A miss optionally writes back the dirty
//               victim, then fills the victim way from the memory arbiter,
//               and returns to IDLE where the held request re-evaluates as
//               a hit.
//
// Ports       : clk, rst_n              clock, async active-low reset
//               mem_read, mem_write     CPU request strobes (held to mem_resp)
//               hit, comp*_out, vba*_out, dba*_out, lru_out
//                                       datapath status flags
//               arb_mem_resp            arbiter completion pulse
//               va*_w, ta*_w, da*_w, dba*_w, la_w
//                                       array write enables
//               lru_in, dba_in          LRU / dirty write data
//               datamux_sel, dawmux_sel, addrmux_sel
//                                       datapath mux selects
//               mem_resp                one-cycle CPU completion
//               arb_mem_read/arb_mem_write
//                                       line fill / writeback requests
//               hit_cnt, miss_cnt, wb_cnt
//                                       saturating performance counters
//
// Option      : PERF_CNT_EN  - when defined, adds the hit/miss/writeback
//                              counters and their ports.
// Revision    : 1.0  initial release
// ============================================================================
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 hit,
    input  logic                 comp0_out,
    input  logic                 comp1_out,
    input  logic                 vba0_out,
    input  logic                 vba1_out,
    input  logic                 dba0_out,
    input  logic                 dba1_out,
    input  logic                 lru_out,
    input  logic                 arb_mem_resp,
    output logic                 va0_w,
    output logic                 va1_w,
    output logic                 ta0_w,
    output logic                 ta1_w,
    output logic                 da0_w,
    output logic                 da1_w,
    output logic                 dba0_w,
    output logic                 dba1_w,
    output logic                 la_w,
    output logic                 lru_in,
    output logic                 dba_in,
    output logic                 datamux_sel,
    output logic                 dawmux_sel,
    output logic [1:0]           addrmux_sel,
    output logic                 mem_resp,
    output logic                 arb_mem_read,
    output logic                 arb_mem_write
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt,
    output logic [CNT_WIDTH-1:0] wb_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t r_state;
    logic   r_victim;

    logic w_req;
    logic w_hit_way;
    logic w_victim_sel;
    logic w_victim_dirty;
    logic w_idle_hit;
    logic w_idle_miss;
    logic w_wb_exit;

    // Way0's compare is implied by hit & ~way1-match, so it is not needed.
    logic w_unused;
    assign w_unused = &{1'b0, comp0_out};

    always_comb begin
        w_req          = mem_read | mem_write;
        w_hit_way      = comp1_out & vba1_out;
        // Fill an invalid way first; only evict by LRU when both are valid.
        if (!vba0_out) begin
            w_victim_sel = 1'b0;
        end else if (!vba1_out) begin
            w_victim_sel = 1'b1;
        end else begin
            w_victim_sel = lru_out;
        end
        w_victim_dirty = w_victim_sel ? (vba1_out & dba1_out)
                                      : (vba0_out & dba0_out);
        w_idle_hit     = (r_state == ST_IDLE) & w_req & hit;
        w_idle_miss    = (r_state == ST_IDLE) & w_req & ~hit;
        w_wb_exit      = (r_state == ST_WRITEBACK) & arb_mem_resp;
    end

    // ------------------------------------------------------------------
    // State and victim register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_victim <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_miss) begin
                        r_victim <= w_victim_sel;
                        r_state  <= w_victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
                ST_WRITEBACK: begin
                    if (arb_mem_resp) begin
                        r_state <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (arb_mem_resp) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. These are decoded combinationally from state and inputs
    // because a hit must be answered in the same cycle it is presented.
    // Gating with rst_n forces every output low for the whole reset window.
    // ------------------------------------------------------------------
    always_comb begin
        va0_w         = 1'b0;
        va1_w         = 1'b0;
        ta0_w         = 1'b0;
        ta1_w         = 1'b0;
        da0_w         = 1'b0;
        da1_w         = 1'b0;
        dba0_w        = 1'b0;
        dba1_w        = 1'b0;
        la_w          = 1'b0;
        lru_in        = 1'b0;
        dba_in        = 1'b0;
        datamux_sel   = 1'b0;
        dawmux_sel    = 1'b0;
        addrmux_sel   = 2'd0;
        mem_resp      = 1'b0;
        arb_mem_read  = 1'b0;
        arb_mem_write = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_idle_hit) begin
                        mem_resp    = 1'b1;
                        datamux_sel = w_hit_way;
                        la_w        = 1'b1;
                        lru_in      = ~w_hit_way;
                        // A write (including read+write) merges CPU data
                        // into the hit way and marks it dirty.
                        if (mem_write) begin
                            dawmux_sel = 1'b0;
                            da0_w      = ~w_hit_way;
                            da1_w      = w_hit_way;
                            dba0_w     = ~w_hit_way;
                            dba1_w     = w_hit_way;
                            dba_in     = 1'b1;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    arb_mem_write = 1'b1;
                    datamux_sel   = r_victim;
                    addrmux_sel   = r_victim ? 2'd2 : 2'd1;
                end
                ST_ALLOCATE: begin
                    arb_mem_read = 1'b1;
                    addrmux_sel  = 2'd0;
                    // Arrays are written only in the cycle the line arrives.
                    if (arb_mem_resp) begin
                        dawmux_sel = 1'b1;
                        dba_in     = 1'b0;
                        da0_w      = ~r_victim;
                        ta0_w      = ~r_victim;
                        va0_w      = ~r_victim;
                        dba0_w     = ~r_victim;
                        da1_w      = r_victim;
                        ta1_w      = r_victim;
                        va1_w      = r_victim;
                        dba1_w     = r_victim;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (w_idle_hit && (hit_cnt != c_cnt_max)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (w_idle_miss && (miss_cnt != c_cnt_max)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if (w_wb_exit && (wb_cnt != c_cnt_max)) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end
`else
    // Counters absent; the width parameter and event decodes are unused.
    logic w_unused_perf;
    assign w_unused_perf = &{1'b0, w_wb_exit, CNT_WIDTH[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_control
// Description : Scoreboard bench for cache_control. Directed stimulus pushes
//               the hand-computed output vector of every active cycle into a
//               queue; a negedge monitor pops and compares whenever the DUT
//               drives any output high.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cache_control;

`ifdef PERF_CNT_EN
    localparam int CW = 3;
`else
    localparam int CW = 16;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic mem_read, mem_write, hit, comp0_out, comp1_out;
    logic vba0_out, vba1_out, dba0_out, dba1_out, lru_out, arb_mem_resp;
    logic va0_w, va1_w, ta0_w, ta1_w, da0_w, da1_w, dba0_w, dba1_w, la_w;
    logic lru_in, dba_in, datamux_sel, dawmux_sel;
    logic [1:0] addrmux_sel;
    logic mem_resp, arb_mem_read, arb_mem_write;
`ifdef PERF_CNT_EN
    logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
        .comp0_out(comp0_out), .comp1_out(comp1_out),
        .vba0_out(vba0_out), .vba1_out(vba1_out),
        .dba0_out(dba0_out), .dba1_out(dba1_out),
        .lru_out(lru_out), .arb_mem_resp(arb_mem_resp),
        .va0_w(va0_w), .va1_w(va1_w), .ta0_w(ta0_w), .ta1_w(ta1_w),
        .da0_w(da0_w), .da1_w(da1_w), .dba0_w(dba0_w), .dba1_w(dba1_w),
        .la_w(la_w), .lru_in(lru_in), .dba_in(dba_in),
        .datamux_sel(datamux_sel), .dawmux_sel(dawmux_sel),
        .addrmux_sel(addrmux_sel), .mem_resp(mem_resp),
        .arb_mem_read(arb_mem_read), .arb_mem_write(arb_mem_write)
`ifdef PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       va0, va1, ta0, ta1, da0, da1, dba0, dba1, la;
        logic       lru_in, dba_in, dsel, dawsel;
        logic [1:0] asel;
        logic       resp, ard, awr;
    } outs_t;

    outs_t q_exp[$];
    int    checks = 0;
    int    errors = 0;

    function automatic outs_t cur();
        outs_t o;
        o = '{va0_w, va1_w, ta0_w, ta1_w, da0_w, da1_w, dba0_w, dba1_w, la_w,
              lru_in, dba_in, datamux_sel, dawmux_sel, addrmux_sel,
              mem_resp, arb_mem_read, arb_mem_write};
        return o;
    endfunction

    // Expected vectors, written from the behavioural description.
    function automatic outs_t o_none();
        outs_t e; e = '0; return e;
    endfunction
    function automatic outs_t o_rd_hit(input bit way);
        outs_t e; e = '0;
        e.resp = 1; e.dsel = way; e.la = 1; e.lru_in = ~way;
        return e;
    endfunction
    function automatic outs_t o_wr_hit(input bit way);
        outs_t e; e = o_rd_hit(way);
        e.dba_in = 1;
        if (way) begin e.da1 = 1; e.dba1 = 1; end
        else     begin e.da0 = 1; e.dba0 = 1; end
        return e;
    endfunction
    function automatic outs_t o_wb(input bit way);
        outs_t e; e = '0;
        e.awr = 1; e.dsel = way; e.asel = way ? 2'd2 : 2'd1;
        return e;
    endfunction
    function automatic outs_t o_alloc();
        outs_t e; e = '0; e.ard = 1; return e;
    endfunction
    function automatic outs_t o_fill(input bit way);
        outs_t e; e = o_alloc();
        e.dawsel = 1;
        if (way) begin e.va1 = 1; e.ta1 = 1; e.da1 = 1; e.dba1 = 1; end
        else     begin e.va0 = 1; e.ta0 = 1; e.da0 = 1; e.dba0 = 1; end
        return e;
    endfunction

    // Monitor: every active output cycle must match the next expected vector.
    always @(negedge clk) begin
        outs_t a, e;
        if (rst_n === 1'b1) begin
            a = cur();
            if (a !== '0) begin
                checks++;
                if (q_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h, required no activity", a);
                end else begin
                    e = q_exp.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL cycle_outputs @%0t: got %h, required %h", $time, a, e);
                    end
                end
            end
        end
    end

    task automatic step(input outs_t e);
        if (e !== '0) q_exp.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic flags(input bit h, c0, c1, v0, v1, d0, d1, l);
        hit = h; comp0_out = c0; comp1_out = c1;
        vba0_out = v0; vba1_out = v1; dba0_out = d0; dba1_out = d1; lru_out = l;
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if (cur() !== '0) begin
            errors++;
            $display("FAIL %s: got %h, required 0", name, cur());
        end
    endtask

`ifdef PERF_CNT_EN
    task automatic chk_cnt(input string name, input logic [CW-1:0] got, input logic [CW-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; mem_read = 0; mem_write = 0; arb_mem_resp = 0;
        flags(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_outputs");
        rst_n = 1'b1;
        step(o_none());

        // Read 0x0040, all invalid: allocate into way0, then hit.
        mem_read = 1;
        step(o_none());
        step(o_alloc());
        step(o_alloc());
        arb_mem_resp = 1; step(o_fill(0));
        arb_mem_resp = 0;
        flags(1, 1, 0, 1, 0, 0, 0, 0);
        step(o_rd_hit(0));
        mem_read = 0; step(o_none());

        // Write 0x0042 hit in way0: zero-wait.
        mem_write = 1; step(o_wr_hit(0));
        mem_write = 0; step(o_none());

        // Write hit way1; read+write treated as write; read hit way1.
        flags(1, 0, 1, 1, 1, 1, 0, 1);
        mem_write = 1; step(o_wr_hit(1));
        mem_read  = 1; step(o_wr_hit(1));
        mem_write = 0; step(o_rd_hit(1));
        mem_read  = 0; step(o_none());

        // Arbiter response while idle is ignored.
        arb_mem_resp = 1; step(o_none());
        arb_mem_resp = 0; step(o_none());

        // Full set, way0 dirty, lru=0: writeback way0 then fill way0.
        flags(0, 0, 0, 1, 1, 1, 0, 0);
        mem_read = 1;
        step(o_none());
        step(o_wb(0));
        step(o_wb(0));
        arb_mem_resp = 1; step(o_wb(0));
        arb_mem_resp = 0; step(o_alloc());
        arb_mem_resp = 1; step(o_fill(0));
        arb_mem_resp = 0;
        flags(1, 1, 0, 1, 1, 0, 0, 0);
        step(o_rd_hit(0));
        mem_read = 0; step(o_none());

        // Full set, lru=1, way1 clean: no writeback, fill way1.
        flags(0, 0, 0, 1, 1, 1, 0, 1);
        mem_read = 1;
        step(o_none());
        step(o_alloc());
        arb_mem_resp = 1; step(o_fill(1));
        arb_mem_resp = 0;
        flags(1, 0, 1, 1, 1, 1, 0, 1);
        step(o_rd_hit(1));
        mem_read = 0; step(o_none());

        // Way1 dirty victim (addrmux=2); request dropped during allocate.
        flags(0, 0, 0, 1, 1, 0, 1, 1);
        mem_write = 1;
        step(o_none());
        arb_mem_resp = 1; step(o_wb(1));
        arb_mem_resp = 0; mem_write = 0; step(o_alloc());
        arb_mem_resp = 1; step(o_fill(1));
        arb_mem_resp = 0; step(o_none());
        step(o_none());

        // Way1 invalid takes priority over lru=0 and a dirty way0.
        flags(0, 0, 0, 1, 0, 1, 0, 0);
        mem_read = 1;
        step(o_none());
        arb_mem_resp = 1; step(o_fill(1));
        arb_mem_resp = 0;
        flags(1, 0, 1, 1, 1, 1, 0, 0);
        step(o_rd_hit(1));
        mem_read = 0; step(o_none());

        // Reset during allocate before the line arrives.
        flags(0, 0, 0, 0, 0, 0, 0, 0);
        mem_read = 1;
        step(o_none());
        step(o_alloc());
        #2 rst_n = 1'b0;
        #1 chk_zero("reset_async_outputs");
        mem_read = 0; arb_mem_resp = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(o_none());
        arb_mem_resp = 0;
        step(o_none());
        step(o_none());

`ifdef PERF_CNT_EN
        // 3 hits + 1 dirty miss (with post-fill hit), counters fresh from reset.
        flags(1, 1, 0, 1, 0, 0, 0, 0);
        mem_read = 1;
        step(o_rd_hit(0)); step(o_rd_hit(0)); step(o_rd_hit(0));
        mem_read = 0; step(o_none());
        flags(0, 0, 0, 1, 1, 1, 0, 0);
        mem_read = 1;
        step(o_none());
        arb_mem_resp = 1; step(o_wb(0));
        step(o_fill(0));
        arb_mem_resp = 0;
        flags(1, 1, 0, 1, 1, 0, 0, 0);
        step(o_rd_hit(0));
        mem_read = 0; step(o_none());
        chk_cnt("hit_cnt", hit_cnt, 3'd4);
        chk_cnt("miss_cnt", miss_cnt, 3'd1);
        chk_cnt("wb_cnt", wb_cnt, 3'd1);
        // Five more hits push hit_cnt past all-ones: it must stick there.
        mem_read = 1;
        repeat (5) step(o_rd_hit(0));
        mem_read = 0; step(o_none());
        chk_cnt("hit_cnt_saturate", hit_cnt, 3'd7);
`endif

        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL missing_outputs: got %0d unconsumed expected cycles, required 0", q_exp.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
